// File: rtl/adder_cla_pipe.sv
// -----------------------------------------------------------------------------
// adder_cla_pipe
//   Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is cut
//   into STAGE_BITS-wide slices, one slice per pipeline stage. Each slice is
//   built from 4-bit CLA groups with group generate/propagate lookahead. The
//   carry between slices is registered. Upper operand bits ride forward in
//   skew registers and resolved low sum bits ride forward in deskew registers,
//   so the result leaves the last stage aligned. Latency is WIDTH/STAGE_BITS
//   cycles and throughput is one beat per cycle. A single global stall holds
//   every stage while the output is valid and not taken.
//
//   Optional feature macro: ADDER_CLA_PIPE_OVF_EN (adds the ovf output).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat (equals advance)
//   a, b       operands
//   ci         carry-in for add; ignored when sub=1
//   sub        0: a+b+ci   1: a-b (a + ~b + 1)
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   s          sum/difference, modulo 2^WIDTH
//   co         carry-out (bit WIDTH of the full sum); for sub, 1 = no borrow
//   ovf        signed overflow (only with ADDER_CLA_PIPE_OVF_EN)
// -----------------------------------------------------------------------------
module adder_cla_pipe #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef ADDER_CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L  = WIDTH / STAGE_BITS;
    localparam int NG = STAGE_BITS / 4;

    // One STAGE_BITS slice: bit g/p, 4-bit group G/P, lookahead across the
    // groups, then lookahead inside each group from its group carry. Every
    // carry is a flat sum-of-products of g/p terms, so nothing ripples.
    // Returns {carry_out, sum}.
    function automatic logic [STAGE_BITS:0] cla_slice(
        input logic [STAGE_BITS-1:0] x,
        input logic [STAGE_BITS-1:0] y,
        input logic                  cin
    );
        logic [STAGE_BITS-1:0] g, p, c;
        logic [NG-1:0]         gg, gp;
        logic [NG:0]           gc;
        logic                  acc, pp;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                acc = acc | (g[4*j+i] & pp);
                pp  = pp & p[4*j+i];
            end
            gg[j] = acc;
            gp[j] = pp;
        end
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = j; i >= 0; i--) begin
                acc = acc | (gg[i] & pp);
                pp  = pp & gp[i];
            end
            gc[j+1] = acc | (pp & cin);
        end
        for (int j = 0; j < NG; j++) begin
            for (int n = 0; n < 4; n++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int i = n - 1; i >= 0; i--) begin
                    acc = acc | (g[4*j+i] & pp);
                    pp  = pp & p[4*j+i];
                end
                c[4*j+n] = acc | (pp & gc[j]);
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = b ^ {WIDTH{sub}};

    genvar k;
    generate
        for (k = 0; k < L; k++) begin : g_stg
            localparam int LO = k * STAGE_BITS;

            // Operand bits still to be resolved, current slice in the low bits.
            logic [WIDTH-LO-1:0]        op_a, op_b;
            logic                       c_in, v_in;
            logic [STAGE_BITS:0]        res;
            logic [LO+STAGE_BITS-1:0]   sum_nxt;
            logic                       vld_p, carry_p;
            logic [LO+STAGE_BITS-1:0]   sum_p;

            if (k == 0) begin : g_head
                assign op_a    = a;
                assign op_b    = b_eff;
                assign c_in    = sub | ci;
                assign v_in    = in_valid;
                assign sum_nxt = res[STAGE_BITS-1:0];
            end else begin : g_body
                assign op_a    = g_stg[k-1].g_skew.opa_p;
                assign op_b    = g_stg[k-1].g_skew.opb_p;
                assign c_in    = g_stg[k-1].carry_p;
                assign v_in    = g_stg[k-1].vld_p;
                assign sum_nxt = {res[STAGE_BITS-1:0], g_stg[k-1].sum_p};
            end

            assign res = cla_slice(op_a[STAGE_BITS-1:0], op_b[STAGE_BITS-1:0], c_in);

            // ---- stage k register boundary ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p   <= 1'b0;
                    carry_p <= 1'b0;
                    sum_p   <= '0;
                end else if (advance) begin
                    vld_p   <= v_in;
                    carry_p <= res[STAGE_BITS];
                    sum_p   <= sum_nxt;
                end
            end

            if (k < L - 1) begin : g_skew
                logic [WIDTH-LO-STAGE_BITS-1:0] opa_p, opb_p;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        opa_p <= '0;
                        opb_p <= '0;
                    end else if (advance) begin
                        opa_p <= op_a[WIDTH-LO-1:STAGE_BITS];
                        opb_p <= op_b[WIDTH-LO-1:STAGE_BITS];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[L-1].vld_p;
    assign s         = g_stg[L-1].sum_p;
    assign co        = g_stg[L-1].carry_p;

`ifdef ADDER_CLA_PIPE_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: c = x ^ y ^ sum.
    logic msb_c;
    assign msb_c = g_stg[L-1].op_a[STAGE_BITS-1] ^ g_stg[L-1].op_b[STAGE_BITS-1]
                 ^ g_stg[L-1].res[STAGE_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= msb_c ^ g_stg[L-1].res[STAGE_BITS];
        end
    end
`endif

endmodule

// File: tb/tb_adder_cla_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_cla_pipe
//   Self-checking bench for adder_cla_pipe. Main instance WIDTH=16,
//   STAGE_BITS=4 (latency 4); second instance STAGE_BITS=16 (latency 1).
//   Expected results are pushed to a queue on accept and popped on emit.
// -----------------------------------------------------------------------------
module tb_adder_cla_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co;
    logic [15:0] a, b, s;
    logic        in_valid1, in_ready1, ci1, sub1, out_valid1, out_ready1, co1;
    logic [15:0] a1, b1, s1;
    logic [17:0] obs, obs1;

    int checks = 0;
    int errors = 0;
    logic [17:0] sb_q[$];

`ifdef ADDER_CLA_PIPE_OVF_EN
    logic ovf, ovf1;
    assign obs  = {ovf, co, s};
    assign obs1 = {ovf1, co1, s1};
    localparam logic [17:0] MASK = 18'h3FFFF;
`else
    assign obs  = {1'b0, co, s};
    assign obs1 = {1'b0, co1, s1};
    localparam logic [17:0] MASK = 18'h1FFFF;
`endif

    always #5 clk = ~clk;

    adder_cla_pipe #(.WIDTH(16), .STAGE_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co)
`ifdef ADDER_CLA_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    adder_cla_pipe #(.WIDTH(16), .STAGE_BITS(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .ci(ci1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .s(s1), .co(co1)
`ifdef ADDER_CLA_PIPE_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Reference: {ovf, co, s}. Overflow when both effective addends share a
    // sign and the result sign differs.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic sb);
        logic [15:0] ye;
        logic [16:0] t;
        logic        v;
        ye = sb ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + {16'd0, (sb ? 1'b1 : c)};
        v  = (x[15] == ye[15]) && (t[15] != x[15]);
        return {v, t[16], t[15:0]} & MASK;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_setup_valid: got %b expected 1", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 00000", obs); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        sb_q.delete();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [15:0] va [5] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000};
        logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] ve [5] = '{18'h10000, 18'h28000, 18'h01235, 18'h0FFFE, 18'h37FFF};
        logic [17:0] e;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; ci = vc[i]; sub = vs[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, in_ready); end
            sb_q.push_back(ve[i] & MASK);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 4", i, lat); end
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL vec%0d_result: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [8];
        logic [15:0] tb_v [8];
        logic        tc [8];
        logic        ts [8];
        logic [17:0] e, prev;
        int idx = 0, emitted = 0, first = -1, last = -1, stall_left = 0;
        for (int i = 0; i < 8; i++) begin
            ta[i] = 16'($urandom); tb_v[i] = 16'($urandom);
            tc[i] = 1'($urandom_range(0, 1)); ts[i] = 1'($urandom_range(0, 1));
        end
        prev = '0;
        for (int cyc = 0; cyc < 60 && emitted < 8; cyc++) begin
            @(negedge clk);
            out_ready = (stall_left == 0);
            in_valid  = (idx < 8);
            if (idx < 8) begin a = ta[idx]; b = tb_v[idx]; ci = tc[idx]; sub = ts[idx]; end
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready: got %b expected 0", in_ready); end
                if (stall_left < 3) begin
                    checks++;
                    if (obs !== prev) begin errors++; $display("FAIL b2b_hold: got %h expected %h", obs, prev); end
                end
                prev = obs;
                stall_left--;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_beat: got %h expected none", obs);
                end else begin
                    e = sb_q.pop_front();
                    if (obs !== e) begin errors++; $display("FAIL b2b_result%0d: got %h expected %h", emitted, obs, e); end
                end
                emitted++;
                if (first < 0) begin first = cyc; stall_left = 3; end
                last = cyc;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, ci, sub));
                idx++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (emitted !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", emitted); end
        checks++;
        if (last - first !== 10) begin errors++; $display("FAIL b2b_span: got %0d expected 10", last - first); end
        checks++;
        if (sb_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", sb_q.size()); end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(i + 1); b = 16'h0100; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL inflight_in_ready%0d: got %b expected 1", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_reset_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL inflight_stale: got %0d results expected 0", seen); end
    endtask

    task automatic test_random();
        logic [17:0] e;
        logic        pend;
        pend = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!pend && cyc < 360 && $urandom_range(0, 9) < 7) begin
                a = 16'($urandom); b = 16'($urandom);
                ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            in_valid  = pend;
            out_ready = (cyc >= 360) || ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++; $display("FAIL rand_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_beat: got %h expected none", obs);
                end else begin
                    e = sb_q.pop_front();
                    if (obs !== e) begin errors++; $display("FAIL rand_result: got %h expected %h", obs, e); end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, ci, sub));
                pend = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sb_q.size() !== 0) begin errors++; $display("FAIL rand_leftover: got %0d expected 0", sb_q.size()); end
    endtask

    task automatic test_stage16();
        logic [15:0] va [2] = '{16'hFFFF, 16'h8000};
        logic [15:0] vb [2] = '{16'h0001, 16'h0001};
        logic        vs [2] = '{1'b0, 1'b1};
        logic [17:0] ve [2] = '{18'h10000, 18'h37FFF};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a1 = va[i]; b1 = vb[i]; ci1 = 1'b0; sub1 = vs[i]; in_valid1 = 1'b1; out_ready1 = 1'b1;
            #1;
            checks++;
            if (in_ready1 !== 1'b1) begin errors++; $display("FAIL s16_in_ready%0d: got %b expected 1", i, in_ready1); end
            @(negedge clk);
            in_valid1 = 1'b0;
            checks++;
            if (out_valid1 !== 1'b1) begin errors++; $display("FAIL s16_latency%0d: got out_valid %b expected 1", i, out_valid1); end
            checks++;
            if (obs1 !== (ve[i] & MASK)) begin errors++; $display("FAIL s16_result%0d: got %h expected %h", i, obs1, ve[i] & MASK); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        test_stage16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_cla_pipe.md
# adder_cla_pipe

- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits a WIDTH-bit operation into STAGE_BITS-wide slices. Each slice is one pipeline stage built from 4-bit CLA groups with group-level generate/propagate lookahead.
- The carry between slices is registered.
- Sits on the datapath's streaming arithmetic path behind a valid/ready handshake. Sustains one operation per cycle with fixed latency.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of STAGE_BITS, 4..64
- STAGE_BITS, 4, bits resolved per pipeline stage; multiple of 4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in; ignored when sub=1
- sub  in  1  0: a+b+ci; 1: a-b (a + ~b + 1)
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference
- co  out  1  carry-out; for sub=1, 1 = no borrow
- ovf  out  1  signed overflow; present only with ADDER_CLA_PIPE_OVF_EN

## Operation
- Stage count L = WIDTH/STAGE_BITS.
- Stage k computes bits [k*STAGE_BITS +: STAGE_BITS] from:
  - skewed operand bits;
  - the registered carry from stage k-1.
- Stage 0 takes carry-in = sub ? 1 : ci.
- In subtract mode B is inverted at input capture.
- Inside a stage:
  - g=a&b and p=a^b per bit;
  - 4-bit group G/P;
  - lookahead across groups;
  - sum = p ^ carry.
  - No ripple across a 4-bit group.
- Upper operand bits travel in skew registers. Resolved lower sum bits travel forward in deskew registers, so s is aligned at the output.
- Each stage holds a valid bit. Bubbles travel as invalid slots.
- Stall is global: advance = !out_valid | out_ready.
  - While advance=0, every stage register holds.
  - Bubbles are not collapsed.
- in_ready = advance (combinational from out_ready and out_valid).
- Accept occurs when in_valid & in_ready. Emit occurs when out_valid & out_ready.
- Arithmetic is modulo 2^WIDTH; co is bit WIDTH of the full sum.

## Timing
- Reset (async assert, sync-safe deassert):
  - all valid bits 0;
  - out_valid=0, s=0, co=0, ovf=0;
  - all skew/carry registers 0.
- in_ready is 1 in the first cycle after reset release.
- Latency is exactly L cycles, from the accepting edge to out_valid high, when there is no stall.
- With L=1 the result is simply registered.
- Throughput is 1 beat/cycle while out_ready=1.
- While out_valid=1 and out_ready=0, s/co/ovf hold stable and in_ready=0.
- Full pipe with out_ready=1 and in_valid=1 in the same cycle: one beat is emitted and one accepted on the same edge. No loss, no duplicate.
- Operands presented while in_ready=0 are not captured; the source must hold them.
- Reset mid-operation: all in-flight beats are discarded. out_valid falls immediately on rst assertion, and no stale result appears after release.
- Results leave in acceptance order.

## Configuration
- Macro: ADDER_CLA_PIPE_OVF_EN.
- Defined:
  - ovf port exists;
  - ovf = carry into bit WIDTH-1 XOR co, registered alongside the final stage;
  - ovf is valid with out_valid.
- Undefined:
  - no ovf port;
  - no overflow logic or register;
  - all other behaviour identical.

## Test plan
WIDTH=16, STAGE_BITS=4 (L=4), macro defined, unless noted.
- **Reset:** rst=1 mid-stream → same cycle out_valid=0, s=0000, co=0, ovf=0; after release in_ready=1.
- **Add with carry-out:** a=FFFF, b=0001, ci=0, sub=0, accepted at cycle t → out_valid at t+4 with s=0000, co=1, ovf=0.
- **Signed overflow and carry-in:**
  - a=7FFF, b=0001, ci=0 → s=8000, co=0, ovf=1.
  - a=1234, b=0000, ci=1 → s=1235, co=0, ovf=0.
- **Subtract:**
  - a=0005, b=0007, sub=1, ci=1 → s=FFFE, co=0, ovf=0.
  - a=8000, b=0001, sub=1 → s=7FFF, co=1, ovf=1.
- **Back-pressure:**
  - Stimulus: 8 back-to-back beats; out_ready=0 for 3 cycles after the first result.
  - Required: in_ready drops; outputs are held stable; all 8 results emerge in order, with no loss or duplicate; throughput returns to 1/cycle.
- **Reset with beats in flight, plus STAGE_BITS=16 build:**
  - Reset with 3 beats in flight → no result is ever emitted for them.
  - Repeat the add scenario with STAGE_BITS=16 → latency 1.
  - Repeat with the macro undefined → compiles without the ovf port.
